// File: rtl/load_extend_unit.sv
// Registered load-data extension for the memory stage: selects the addressed bytes of a read
// beat, sign- or zero-extends them, and stitches boundary-crossing loads from two beats.
module load_extend_unit #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned ALLOW_MISALIGNED = 1,
  parameter int unsigned OFF_W            = $clog2(DATA_WIDTH / 8)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [OFF_W-1:0]      in_offset,
  input  logic [4:0]            in_sx_op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_err
);

  // isa_shared extension op encoding
  localparam logic [4:0] SX_0700  = 5'd0;
  localparam logic [4:0] SXU_0700 = 5'd1;
  localparam logic [4:0] SX_1500  = 5'd2;
  localparam logic [4:0] SXU_1500 = 5'd3;
  localparam logic [4:0] SX_3100  = 5'd4;
  localparam logic [4:0] SXU_3100 = 5'd5;
  localparam logic [4:0] SX_6300  = 5'd6;
  localparam logic [4:0] SX_1100  = 5'd7;
  localparam logic [4:0] SX_2000  = 5'd8;

  localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;
  localparam int unsigned IDX_W      = $clog2(DATA_WIDTH);
  localparam logic [OFF_W:0] BEAT_BYTES_W = BEAT_BYTES[OFF_W:0];

  typedef enum logic [0:0] {S_IDLE, S_HI} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] lo_q;
  logic [OFF_W-1:0]      off_q;
  logic [4:0]            op_q;

  logic [4:0]              cur_op;
  logic [OFF_W-1:0]        cur_off;
  logic [6:0]              nbits;
  logic                    sgn;
  logic                    imm;
  logic                    legal;
  logic [OFF_W:0]          nbytes;
  logic [OFF_W:0]          end_pos;
  logic                    crossing;
  logic                    err;
  logic [OFF_W+2:0]        shamt;
  logic [2*DATA_WIDTH-1:0] window;
  logic [DATA_WIDTH-1:0]   sel;
  logic [IDX_W-1:0]        top_idx;
  logic                    fill;
  logic [DATA_WIDTH-1:0]   ext_val;
  logic [DATA_WIDTH-1:0]   result;

  assign in_ready = !out_valid || out_ready;

  always_comb begin
    // The second beat reuses the offset and op captured with the first beat.
    cur_op  = (state_q == S_HI) ? op_q : in_sx_op;
    cur_off = (state_q == S_HI) ? off_q : in_offset;

    nbits = 7'd0;
    sgn   = 1'b0;
    imm   = 1'b0;
    legal = 1'b1;
    case (cur_op)
      SX_0700:  begin nbits = 7'd8;  sgn = 1'b1; end
      SXU_0700: begin nbits = 7'd8;  end
      SX_1500:  begin nbits = 7'd16; sgn = 1'b1; end
      SXU_1500: begin nbits = 7'd16; end
      SX_3100:  begin nbits = 7'd32; sgn = 1'b1; end
      SXU_3100: begin nbits = 7'd32; legal = (DATA_WIDTH == 64); end
      SX_6300:  begin nbits = 7'd64; legal = (DATA_WIDTH == 64); end
      SX_1100:  begin nbits = 7'd12; sgn = 1'b1; imm = 1'b1; end
      SX_2000:  begin nbits = 7'd21; sgn = 1'b1; imm = 1'b1; end
      default:  legal = 1'b0;
    endcase

    nbytes   = (OFF_W + 1)'(nbits >> 3);
    end_pos  = {1'b0, cur_off} + nbytes;
    crossing = legal && !imm && (end_pos > BEAT_BYTES_W);
    err      = !legal || (crossing && (ALLOW_MISALIGNED == 0));

    window = (state_q == S_HI) ? {in_data, lo_q} : {{DATA_WIDTH{1'b0}}, in_data};
    shamt  = imm ? '0 : {cur_off, 3'b000};
    sel    = DATA_WIDTH'(window >> shamt);

    top_idx = IDX_W'(nbits - 7'd1);
    fill    = sgn & sel[top_idx];
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      ext_val[i] = (i < int'(nbits)) ? sel[i] : fill;
    end

    result = err ? '0 : ext_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      lo_q      <= '0;
      off_q     <= '0;
      op_q      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else begin
      if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (in_valid && in_ready) begin
        if (state_q == S_IDLE && crossing && !err) begin
          lo_q    <= in_data;
          off_q   <= in_offset;
          op_q    <= in_sx_op;
          state_q <= S_HI;
        end else begin
          out_valid <= 1'b1;
          out_data  <= result;
          out_err   <= err;
          state_q   <= S_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_load_extend_unit.sv
// Scoreboard bench for load_extend_unit: three instances (32-bit stitching, 32-bit strict,
// 64-bit stitching) driven with directed beats; monitors pop expected results on handshake.
module tb_load_extend_unit;

  localparam logic [4:0] SX_0700  = 5'd0;
  localparam logic [4:0] SXU_0700 = 5'd1;
  localparam logic [4:0] SX_1500  = 5'd2;
  localparam logic [4:0] SXU_1500 = 5'd3;
  localparam logic [4:0] SX_3100  = 5'd4;
  localparam logic [4:0] SXU_3100 = 5'd5;
  localparam logic [4:0] SX_6300  = 5'd6;
  localparam logic [4:0] SX_1100  = 5'd7;
  localparam logic [4:0] SX_2000  = 5'd8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
  logic [31:0] a_in_data, a_out_data;
  logic [1:0]  a_in_offset;
  logic [4:0]  a_in_sx_op;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
  logic [31:0] b_in_data, b_out_data;
  logic [1:0]  b_in_offset;
  logic [4:0]  b_in_sx_op;

  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_err;
  logic [63:0] c_in_data, c_out_data;
  logic [2:0]  c_in_offset;
  logic [4:0]  c_in_sx_op;

  load_extend_unit #(.DATA_WIDTH(32), .ALLOW_MISALIGNED(1)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_offset(a_in_offset), .in_sx_op(a_in_sx_op), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_err(a_out_err)
  );

  load_extend_unit #(.DATA_WIDTH(32), .ALLOW_MISALIGNED(0)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_offset(b_in_offset), .in_sx_op(b_in_sx_op), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_err(b_out_err)
  );

  load_extend_unit #(.DATA_WIDTH(64), .ALLOW_MISALIGNED(1)) u_dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .in_offset(c_in_offset), .in_sx_op(c_in_sx_op), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_data(c_out_data), .out_err(c_out_err)
  );

  typedef struct {
    logic [63:0] data;
    logic        err;
    string       tag;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, {63'd0, act}, {63'd0, exp});
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: in_ready never rose within the cycle budget", name);
  endtask

  function automatic exp_t mk(input logic [63:0] d, input logic e, input string t);
    exp_t x;
    x.data = d;
    x.err  = e;
    x.tag  = t;
    return x;
  endfunction

  // Monitors: a result is consumed at the edge following a negedge with valid && ready.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL a_unexpected: got 0x%0h, expected no output", a_out_data);
      end else begin
        e = qa.pop_front();
        check({e.tag, "_data"}, {32'd0, a_out_data}, e.data);
        check_bit({e.tag, "_err"}, a_out_err, e.err);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL b_unexpected: got 0x%0h, expected no output", b_out_data);
      end else begin
        e = qb.pop_front();
        check({e.tag, "_data"}, {32'd0, b_out_data}, e.data);
        check_bit({e.tag, "_err"}, b_out_err, e.err);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && c_out_valid && c_out_ready) begin
      if (qc.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL c_unexpected: got 0x%0h, expected no output", c_out_data);
      end else begin
        e = qc.pop_front();
        check({e.tag, "_data"}, c_out_data, e.data);
        check_bit({e.tag, "_err"}, c_out_err, e.err);
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Beat tasks are entered just after a rising edge and return just after the accepting edge.
  task automatic a_beat(input logic [31:0] d, input logic [1:0] off, input logic [4:0] op);
    int n = 0;
    a_in_valid  = 1'b1;
    a_in_data   = d;
    a_in_offset = off;
    a_in_sx_op  = op;
    @(negedge clk);
    while (!a_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!a_in_ready) timeout_fail("a_accept_timeout");
    sync();
    a_in_valid = 1'b0;
  endtask

  task automatic b_beat(input logic [31:0] d, input logic [1:0] off, input logic [4:0] op);
    int n = 0;
    b_in_valid  = 1'b1;
    b_in_data   = d;
    b_in_offset = off;
    b_in_sx_op  = op;
    @(negedge clk);
    while (!b_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!b_in_ready) timeout_fail("b_accept_timeout");
    sync();
    b_in_valid = 1'b0;
  endtask

  task automatic c_beat(input logic [63:0] d, input logic [2:0] off, input logic [4:0] op);
    int n = 0;
    c_in_valid  = 1'b1;
    c_in_data   = d;
    c_in_offset = off;
    c_in_sx_op  = op;
    @(negedge clk);
    while (!c_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!c_in_ready) timeout_fail("c_accept_timeout");
    sync();
    c_in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc_start;
    int cyc_end;
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_in_offset = '0; a_in_sx_op = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_offset = '0; b_in_sx_op = '0; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_data = '0; c_in_offset = '0; c_in_sx_op = '0; c_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check_bit("rst_a_valid", a_out_valid, 1'b0);
    check("rst_a_data", {32'd0, a_out_data}, 64'd0);
    check_bit("rst_a_err", a_out_err, 1'b0);
    check_bit("rst_a_in_ready", a_in_ready, 1'b1);
    check_bit("rst_b_valid", b_out_valid, 1'b0);
    check("rst_b_data", {32'd0, b_out_data}, 64'd0);
    check_bit("rst_b_in_ready", b_in_ready, 1'b1);
    check_bit("rst_c_valid", c_out_valid, 1'b0);
    check("rst_c_data", c_out_data, 64'd0);
    check_bit("rst_c_in_ready", c_in_ready, 1'b1);
    sync();

    // Signed byte with one-cycle latency.
    qa.push_back(mk(64'hFFFFFF80, 1'b0, "sx0700_off3"));
    a_beat(32'h80123456, 2'd3, SX_0700);
    @(negedge clk);
    check_bit("sx0700_latency", a_out_valid, 1'b1);
    sync();

    // Back-to-back single-beat loads, immediates and error ops.
    qa.push_back(mk(64'h0000ABCD, 1'b0, "sxu1500_off1"));
    qa.push_back(mk(64'hFFFFF800, 1'b0, "sx1100_imm"));
    qa.push_back(mk(64'hFFF00000, 1'b0, "sx2000_imm"));
    qa.push_back(mk(64'h000000CC, 1'b0, "sxu0700_off2"));
    qa.push_back(mk(64'hFFFF8001, 1'b0, "sx1500_off2"));
    qa.push_back(mk(64'h0, 1'b1, "unknown_op"));
    qa.push_back(mk(64'h0, 1'b1, "sxu3100_on32"));
    qa.push_back(mk(64'h0, 1'b1, "sx6300_on32"));
    cyc_start = cyc;
    a_beat(32'h00ABCD00, 2'd1, SXU_1500);
    a_beat(32'h00000800, 2'd3, SX_1100);
    a_beat(32'h00100000, 2'd2, SX_2000);
    a_beat(32'h00CC0000, 2'd2, SXU_0700);
    a_beat(32'h80010000, 2'd2, SX_1500);
    a_beat(32'h12345678, 2'd0, 5'd31);
    a_beat(32'hFFFFFFFF, 2'd0, SXU_3100);
    a_beat(32'hFFFFFFFF, 2'd0, SX_6300);
    cyc_end = cyc;
    check("throughput_cycles", 64'(cyc_end - cyc_start), 64'd8);

    // Misaligned word across two beats; op on the second beat must be ignored.
    qa.push_back(mk(64'h77881122, 1'b0, "mis_word"));
    a_beat(32'h11223344, 2'd2, SX_3100);
    @(negedge clk);
    check_bit("mis_word_no_out_beat1", a_out_valid, 1'b0);
    sync();
    a_beat(32'h55667788, 2'd0, SXU_0700);
    @(negedge clk);
    check_bit("mis_word_latency", a_out_valid, 1'b1);
    sync();

    qa.push_back(mk(64'hFFFFFF80, 1'b0, "mis_half"));
    a_beat(32'h80AABBCC, 2'd3, SX_1500);
    a_beat(32'h000000FF, 2'd1, 5'd31);

    // Strict instance: crossing is an error, next beat is a fresh first beat.
    qb.push_back(mk(64'h0, 1'b1, "nm_cross"));
    b_beat(32'h12345678, 2'd3, SX_1500);
    @(negedge clk);
    check_bit("nm_cross_single_beat", b_out_valid, 1'b1);
    sync();
    qb.push_back(mk(64'h0000007F, 1'b0, "nm_next_first"));
    b_beat(32'h0000007F, 2'd0, SX_0700);
    qb.push_back(mk(64'hFFFF8001, 1'b0, "nm_aligned_half"));
    b_beat(32'h80010000, 2'd2, SX_1500);
    repeat (2) sync();

    // Backpressure: hold out_ready low, then release together with a pending beat.
    a_out_ready = 1'b0;
    qa.push_back(mk(64'h0000005A, 1'b0, "bp_first"));
    a_beat(32'h0000005A, 2'd0, SXU_0700);
    qa.push_back(mk(64'hFFFFFF80, 1'b0, "bp_second"));
    a_in_valid  = 1'b1;
    a_in_data   = 32'h00008000;
    a_in_offset = 2'd1;
    a_in_sx_op  = SX_0700;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_bit("bp_in_ready_low", a_in_ready, 1'b0);
      check_bit("bp_valid_held", a_out_valid, 1'b1);
      check("bp_data_held", {32'd0, a_out_data}, 64'h5A);
      check_bit("bp_err_held", a_out_err, 1'b0);
    end
    sync();
    a_out_ready = 1'b1;
    @(negedge clk);
    check_bit("bp_in_ready_release", a_in_ready, 1'b1);
    sync();
    a_in_valid = 1'b0;
    @(negedge clk);
    check_bit("bp_no_bubble_valid", a_out_valid, 1'b1);
    check("bp_no_bubble_data", {32'd0, a_out_data}, 64'hFFFFFF80);
    repeat (2) sync();

    // Reset while waiting for the second beat discards the first beat.
    a_beat(32'hAABBCCDD, 2'd1, SX_3100);
    rst = 1'b1;
    sync();
    rst = 1'b0;
    @(negedge clk);
    check_bit("rst_in_hi_valid", a_out_valid, 1'b0);
    check_bit("rst_in_hi_in_ready", a_in_ready, 1'b1);
    sync();
    qa.push_back(mk(64'h000000FF, 1'b0, "after_rst_first"));
    a_beat(32'h000000FF, 2'd0, SXU_0700);
    @(negedge clk);
    check_bit("after_rst_latency", a_out_valid, 1'b1);
    sync();

    // 64-bit instance.
    qc.push_back(mk(64'h01234567_89ABCDEF, 1'b0, "w64_sx6300_cross"));
    c_beat(64'h89ABCDEF_00000000, 3'd4, SX_6300);
    @(negedge clk);
    check_bit("w64_no_out_beat1", c_out_valid, 1'b0);
    sync();
    c_beat(64'h00000000_01234567, 3'd0, SX_0700);
    @(negedge clk);
    check_bit("w64_latency", c_out_valid, 1'b1);
    sync();
    qc.push_back(mk(64'h00000000_80000000, 1'b0, "w64_sxu3100"));
    c_beat(64'h80000000_00000000, 3'd4, SXU_3100);
    qc.push_back(mk(64'hFFFFFFFF_80000000, 1'b0, "w64_sx3100"));
    c_beat(64'h00000000_80000000, 3'd0, SX_3100);
    qc.push_back(mk(64'hFFFFFFFF_FFFFFF80, 1'b0, "w64_sx0700_off7"));
    c_beat(64'h80000000_00000000, 3'd7, SX_0700);
    repeat (3) sync();

    check("qa_drained", 64'(qa.size()), 64'd0);
    check("qb_drained", 64'(qb.size()), 64'd0);
    check("qc_drained", 64'(qc.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
